// File: rtl/arbiter_puf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arbiter_puf_pkg : shared types, widths and LFSR step for arbiter_puf_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
package arbiter_puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RELAX  = 3'd2,
    ST_FIRE   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DECIDE = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  localparam logic [7:0]  DEFAULT_TAPS      = 8'hB8;
  localparam int unsigned DEFAULT_VOTES     = 5;
  localparam int unsigned DEFAULT_RESP_BITS = 16;

  function automatic int unsigned vote_cnt_w(input int unsigned votes);
    return $clog2(votes + 1);
  endfunction

  function automatic int unsigned bit_cnt_w(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

  localparam int unsigned VOTE_CNT_W = vote_cnt_w(DEFAULT_VOTES);
  localparam int unsigned BIT_CNT_W  = bit_cnt_w(DEFAULT_RESP_BITS);

  // Fibonacci step on the low `size` bits: shift left, feedback parity into LSB.
  function automatic logic [63:0] lfsr_step(input logic [63:0] c,
                                            input logic [63:0] taps,
                                            input int unsigned size);
    logic [63:0] mask;
    mask = (size >= 64) ? '1 : ((64'd1 << size) - 64'd1);
    return ((c << 1) | {63'd0, ^(c & taps & mask)}) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/puf_sync2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// puf_sync2 : two-flop synchronizer for the asynchronous arbiter output
// Revision: 1.0
// ---------------------------------------------------------------------------
module puf_sync2
  import arbiter_puf_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule
`default_nettype wire

// File: rtl/arbiter_puf_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arbiter_puf_ctrl : LFSR challenge sequencer, majority-voting response builder
// Revision: 1.0
// ---------------------------------------------------------------------------
module arbiter_puf_ctrl
  import arbiter_puf_pkg::*;
#(
  parameter int unsigned     SIZE      = 8,
  parameter int unsigned     RESP_BITS = DEFAULT_RESP_BITS,
  parameter int unsigned     SETTLE    = 4,
  parameter int unsigned     VOTES     = DEFAULT_VOTES,
  parameter logic [SIZE-1:0] TAPS      = SIZE'(DEFAULT_TAPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SIZE-1:0]      seed,
  output logic                 busy,
  output logic                 puf_enable,
  output logic [SIZE-1:0]      puf_challenge,
  input  logic                 puf_response,
  output logic [RESP_BITS-1:0] resp_data,
  output logic [RESP_BITS-1:0] unstable,
  output logic                 resp_valid,
  input  logic                 resp_ready
);

  if (SETTLE < 3) begin : g_chk_settle
    $error("arbiter_puf_ctrl: SETTLE must be at least 3");
  end
  if ((VOTES < 1) || (VOTES % 2 == 0)) begin : g_chk_votes
    $error("arbiter_puf_ctrl: VOTES must be odd and at least 1");
  end
  if ((SIZE < 2) || (SIZE > 64)) begin : g_chk_size
    $error("arbiter_puf_ctrl: SIZE must be within 2..64");
  end
  if (RESP_BITS < 2) begin : g_chk_bits
    $error("arbiter_puf_ctrl: RESP_BITS must be at least 2");
  end

  localparam int unsigned VW = vote_cnt_w(VOTES);
  localparam int unsigned BW = bit_cnt_w(RESP_BITS);
  localparam int unsigned SW = $clog2(SETTLE);

  localparam logic [VW-1:0] VOTES_C     = VW'(VOTES);
  localparam logic [VW-1:0] MAJ_C       = VW'(VOTES / 2);
  localparam logic [BW-1:0] RESP_BITS_C = BW'(RESP_BITS);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  state_e                 state_q,  state_d;
  logic [SIZE-1:0]        chal_q,   chal_d;
  logic [BW-1:0]          bits_q,   bits_d;
  logic [VW-1:0]          votes_q,  votes_d;
  logic [VW-1:0]          ones_q,   ones_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic [RESP_BITS-1:0]   data_q,   data_d;
  logic [RESP_BITS-1:0]   unst_q,   unst_d;
  logic                   en_q,     en_d;

  logic                   resp_sync;
  logic [SIZE-1:0]        chal_next;

  puf_sync2 u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (puf_response),
    .sync_out (resp_sync)
  );

  assign chal_next = SIZE'(lfsr_step(64'(chal_q), 64'(TAPS), SIZE));

  always_comb begin
    state_d  = state_q;
    chal_d   = chal_q;
    bits_d   = bits_q;
    votes_d  = votes_q;
    ones_d   = ones_q;
    settle_d = settle_q;
    data_d   = data_q;
    unst_d   = unst_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // An all-zero challenge would lock the LFSR, so substitute 1.
          chal_d  = (seed == '0) ? SIZE'(1) : seed;
          bits_d  = '0;
          votes_d = '0;
          ones_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        votes_d  = '0;
        ones_d   = '0;
        settle_d = '0;
        state_d  = ST_RELAX;
      end
      ST_RELAX: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_FIRE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_FIRE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_SAMPLE: begin
        ones_d  = ones_q + VW'(resp_sync);
        votes_d = votes_q + VW'(1);
        state_d = (votes_d < VOTES_C) ? ST_RELAX : ST_DECIDE;
      end
      ST_DECIDE: begin
        data_d = {data_q[RESP_BITS-2:0], (ones_q > MAJ_C)};
        unst_d = {unst_q[RESP_BITS-2:0], ((ones_q != '0) && (ones_q != VOTES_C))};
        bits_d = bits_q + BW'(1);
        if (bits_d < RESP_BITS_C) begin
          chal_d  = chal_next;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered so the launch edge into the chain is glitch-free.
    en_d = (state_d == ST_FIRE) || (state_d == ST_SAMPLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      chal_q   <= '0;
      bits_q   <= '0;
      votes_q  <= '0;
      ones_q   <= '0;
      settle_q <= '0;
      data_q   <= '0;
      unst_q   <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      chal_q   <= chal_d;
      bits_q   <= bits_d;
      votes_q  <= votes_d;
      ones_q   <= ones_d;
      settle_q <= settle_d;
      data_q   <= data_d;
      unst_q   <= unst_d;
      en_q     <= en_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign puf_enable    = en_q;
  assign puf_challenge = chal_q;
  assign resp_data     = data_q;
  assign unstable      = unst_q;
  assign resp_valid    = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_arbiter_puf_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_arbiter_puf_ctrl : scoreboard bench with a behavioural PUF chain model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_arbiter_puf_ctrl;

  localparam int SIZE    = 8;
  localparam int RB      = 16;
  localparam int SETTLE  = 4;
  localparam int VOTES   = 5;
  localparam int BIT_CYC = VOTES * (2 * SETTLE + 1) + 2;
  localparam int LAT     = RB * BIT_CYC;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_stim = 1'b0;
  logic            start_noise = 1'b0;
  logic            start;
  logic [SIZE-1:0] seed = '0;
  logic            busy;
  logic            puf_enable;
  logic [SIZE-1:0] puf_challenge;
  logic            puf_response = 1'b0;
  logic [RB-1:0]   resp_data;
  logic [RB-1:0]   unstable;
  logic            resp_valid;
  logic            resp_ready = 1'b0;

  assign start = start_stim | start_noise;

  arbiter_puf_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .seed          (seed),
    .busy          (busy),
    .puf_enable    (puf_enable),
    .puf_challenge (puf_challenge),
    .puf_response  (puf_response),
    .resp_data     (resp_data),
    .unstable      (unstable),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [RB-1:0] data;
    logic [RB-1:0] unst;
    int            t0;
    int            hold;
  } exp_t;

  exp_t            sb[$];
  logic [SIZE-1:0] exp_ch [RB];
  logic            vote_tab [RB*VOTES];
  int              done_cnt = 0;

  // Chain model: each evaluation's answer comes from vote_tab, valid 2 cycles after enable.
  initial begin
    int   eval_cnt = 0;
    int   en_cycles = 0;
    int   e = 0;
    logic en_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!busy) eval_cnt = 0;
      if (puf_enable && !en_prev) begin
        e = eval_cnt;
        eval_cnt++;
        en_cycles = 0;
        if (e < RB * VOTES) chk("challenge", 32'(puf_challenge), 32'(exp_ch[e / VOTES]));
        else                chk("eval_count", e, RB * VOTES - 1);
      end
      if (puf_enable) en_cycles++;
      puf_response = (puf_enable && en_cycles >= 3 && e < RB * VOTES) ? vote_tab[e] : 1'b0;
      en_prev = puf_enable;
    end
  end

  // Monitor: pops and compares on each presented word, then applies backpressure.
  initial begin
    exp_t          e;
    logic [RB-1:0] snap_d, snap_u;
    forever begin
      @(posedge clk); #1;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
          @(negedge clk); resp_ready = 1'b1;
        end else begin
          e = sb.pop_front();
          chk("resp_data", 32'(resp_data), 32'(e.data));
          chk("unstable", 32'(unstable), 32'(e.unst));
          chk("latency", cyc - e.t0, LAT);
          snap_d = resp_data;
          snap_u = unstable;
          for (int i = 0; i < e.hold; i++) begin
            @(negedge clk);
            resp_ready  = 1'b0;
            start_noise = 1'($urandom % 2);
            @(posedge clk); #1;
            chk("hold_valid", 32'(resp_valid), 1);
            chk("hold_data", 32'(resp_data), 32'(snap_d));
            chk("hold_unstable", 32'(unstable), 32'(snap_u));
          end
          @(negedge clk);
          start_noise = 1'b0;
          resp_ready  = 1'b1;
          @(posedge clk); #1;
          chk("post_xfer_busy", 32'(busy), 0);
          chk("post_xfer_valid", 32'(resp_valid), 0);
          done_cnt++;
          @(negedge clk); resp_ready = 1'b0;
        end
      end else begin
        @(negedge clk);
        resp_ready = 1'($urandom % 2);
      end
    end
  end

  // mode 0: every vote is the chain's parity; 1: first challenge gives k ones; 2: random noise.
  task automatic prep(input logic [SIZE-1:0] s, input int mode, input int k,
                      output logic [RB-1:0] d, output logic [RB-1:0] u);
    logic [SIZE-1:0] c;
    logic            par;
    int              ones;
    c = (s == '0) ? SIZE'(1) : s;
    for (int b = 0; b < RB; b++) begin
      exp_ch[b] = c;
      par = ^c;
      ones = 0;
      for (int v = 0; v < VOTES; v++) begin
        case (mode)
          0:       vote_tab[b*VOTES+v] = par;
          1:       vote_tab[b*VOTES+v] = (b == 0) ? (v < k) : par;
          default: vote_tab[b*VOTES+v] = ($urandom % 2 == 0) ? par : 1'($urandom % 2);
        endcase
        ones += int'(vote_tab[b*VOTES+v]);
      end
      d[RB-1-b] = (2 * ones > VOTES);
      u[RB-1-b] = (ones != 0) && (ones != VOTES);
      c = {c[SIZE-2:0], ^(c & 8'hB8)};
    end
  endtask

  task automatic run_txn(input logic [SIZE-1:0] s, input int mode, input int k,
                         input int hold, input bit wait_done, output int t0);
    exp_t          e;
    logic [RB-1:0] d, u;
    int            d0, n;
    prep(s, mode, k, d, u);
    @(negedge clk);
    chk("idle_before_start", 32'(busy), 0);
    seed = s;
    start_stim = 1'b1;
    @(posedge clk); #1;
    start_stim = 1'b0;
    t0 = cyc;
    e.data = d; e.unst = u; e.t0 = t0; e.hold = hold;
    sb.push_back(e);
    seed = SIZE'($urandom);
    chk("busy_after_start", 32'(busy), 1);
    if (wait_done) begin
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < LAT + hold + 50) begin
        @(posedge clk); #2;
        n++;
      end
      chk("txn_complete", 32'(done_cnt != d0), 1);
    end
  endtask

  initial begin
    int t0, cnt, n;
    logic [RB-1:0] d, u;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_enable", 32'(puf_enable), 0);
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_challenge", 32'(puf_challenge), 0);
    chk("rst_data", 32'(resp_data), 0);
    chk("rst_unstable", 32'(unstable), 0);
    cnt = 0;
    repeat (100) begin @(posedge clk); #1; if (busy) cnt++; end
    chk("idle_stays_idle", cnt, 0);

    run_txn(8'h01, 0, 0, 20, 1, t0);
    run_txn(8'h00, 0, 0, 2, 1, t0);
    run_txn(8'h01, 1, 3, 0, 1, t0);
    run_txn(8'h01, 1, 2, 1, 1, t0);
    for (int i = 0; i < 4; i++) begin
      run_txn(SIZE'($urandom), 2, 0, int'($urandom_range(0, 5)), 1, t0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // Abort mid-race and confirm nothing is ever presented.
    run_txn(SIZE'($urandom), 2, 0, 0, 0, t0);
    n = 0;
    while (n < 400) begin
      @(posedge clk); #1;
      n++;
      if ((cyc - t0 >= 300) && puf_enable) break;
    end
    chk("abort_reached_fire", 32'(puf_enable), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_enable", 32'(puf_enable), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(resp_valid), 0);
    sb.delete();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    cnt = 0;
    repeat (LAT + 50) begin @(posedge clk); #1; if (resp_valid || busy) cnt++; end
    chk("abort_no_word", cnt, 0);
    run_txn(SIZE'($urandom), 2, 0, 3, 1, t0);
    prep(8'h01, 0, 0, d, u);
    run_txn(8'h01, 0, 0, 0, 1, t0);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
